// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues sequential PC requests under a credit rule,
// queues in-order responses for decode, and squashes stale work on a redirect.
module fetch_queue #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               br_taken,
    input  logic               br_uncond,
    input  logic [25:0]        br_imm,
    input  logic [ADDR_W-1:0]  br_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               decode_ready,
    output logic               err_spurious
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t             q_mem [DEPTH];
    logic [ADDR_W-1:0]  fetch_pc, resp_pc;
    logic [CNT_W-1:0]   count;
    logic [OUT_W-1:0]   inflight, discard;
    logic [PTR_W-1:0]   head, tail;

    logic               rsp_ok, push, pop;
    logic signed [25:0] imm_s;
    logic [ADDR_W-1:0]  offset, target;

    // A response with nothing outstanding is flagged but otherwise ignored,
    // so it can neither underflow inflight nor overflow the queue.
    assign rsp_ok      = imem_rvalid && (inflight != '0);
    assign push        = rsp_ok && !br_taken && (discard == '0);
    assign instr_valid = (count != '0) && !br_taken;
    assign pop         = instr_valid && decode_ready;

    assign imem_req  = !reset && !br_taken
                     && (32'(inflight) < MAX_OUT)
                     && (32'(count) + 32'(inflight) < DEPTH);
    assign imem_addr = fetch_pc;

    assign imm_s  = br_uncond ? br_imm : {{7{br_imm[18]}}, br_imm[18:0]};
    assign offset = ADDR_W'(imm_s);
    assign target = br_pc + (offset << 2);

    assign instr    = q_mem[head].instr;
    assign instr_pc = q_mem[head].pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            resp_pc      <= RESET_PC;
            count        <= '0;
            inflight     <= '0;
            discard      <= '0;
            head         <= '0;
            tail         <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (imem_rvalid && inflight == '0)
                err_spurious <= 1'b1;
            if (br_taken) begin
                // Everything still in flight belongs to the wrong path.
                fetch_pc <= target;
                resp_pc  <= target;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                inflight <= inflight - OUT_W'(rsp_ok);
                discard  <= inflight - OUT_W'(rsp_ok);
            end else begin
                if (imem_req)
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                inflight <= inflight + OUT_W'(imem_req) - OUT_W'(rsp_ok);
                if (rsp_ok && discard != '0)
                    discard <= discard - 1'b1;
                if (push) begin
                    resp_pc <= resp_pc + ADDR_W'(4);
                    tail    <= tail + 1'b1;
                end
                if (pop)
                    head <= head + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            q_mem[tail] <= '{pc: resp_pc, instr: imem_rdata};
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a latency-configurable memory model and a
// scoreboard of expected {pc, instr} pops loaded by each test step.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata = '0;
    logic        br_taken = 1'b0, br_uncond = 1'b0;
    logic [25:0] br_imm = '0;
    logic [63:0] br_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        decode_ready = 1'b0;
    logic        err_spurious;

    logic mem_rv = 1'b0, inj_rv = 1'b0;
    assign imem_rvalid = mem_rv | inj_rv;

    fetch_queue #(.ADDR_W(64), .INSTR_W(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(64'h100)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .br_taken(br_taken),
        .br_uncond(br_uncond), .br_imm(br_imm), .br_pc(br_pc), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .decode_ready(decode_ready),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int due; } pend_t;
    pend_t       pend[$];
    logic [63:0] sb[$];
    int vectors = 0, miscompares = 0;
    int cyc = 0, lat = 1, nreq = 0, pops = 0, first_pop = 0, last_pop = 0;

    function automatic logic [31:0] mem_word(logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: observe the current cycle, clock it, then drive the memory
    // response for the following cycle.
    task automatic tick();
        logic [63:0] e;
        #1;
        if (instr_valid && decode_ready) begin
            if (sb.size() == 0) begin
                miscompares++;
                $error("FAIL unexpected_pop: observed pc %h expected no pop", instr_pc);
            end else begin
                e = sb.pop_front();
                chk("pop_pc", instr_pc, e);
                chk("pop_instr", {32'h0, instr}, {32'h0, mem_word(e)});
            end
            if (pops == 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
        end
        if (imem_req) begin
            pend.push_back('{addr: imem_addr, due: cyc + lat});
            nreq++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rv     = 1'b1;
            imem_rdata = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            mem_rv = 1'b0;
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(int latency);
        #1;
        reset = 1'b1;
        mem_rv = 1'b0; inj_rv = 1'b0; br_taken = 1'b0; decode_ready = 1'b0;
        pend.delete(); sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_err", err_spurious, 0);
        chk("rst_addr", imem_addr, 64'h100);
        reset = 1'b0;
        lat = latency; cyc = 0; nreq = 0; pops = 0;
    endtask

    task automatic expect_run(logic [63:0] start, int n);
        for (int i = 0; i < n; i++) sb.push_back(start + 64'(4 * i));
    endtask

    task automatic drain(int max);
        int n = 0;
        decode_ready = 1'b1;
        while (sb.size() > 0 && n < max) begin
            tick();
            n++;
        end
        if (sb.size() > 0) begin
            miscompares++;
            $error("FAIL drain_timeout: observed %0d entries left expected 0", sb.size());
        end
        decode_ready = 1'b0;
    endtask

    task automatic branch(logic uncond, logic [25:0] imm, logic [63:0] pc);
        br_taken = 1'b1; br_uncond = uncond; br_imm = imm; br_pc = pc;
    endtask

    initial begin
        // Reset values, first request, steady one-per-cycle stream
        do_reset(1);
        #1;
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 64'h100);
        expect_run(64'h100, 8);
        drain(30);
        chk("steady_rate", 64'(last_pop - first_pop), 7);

        // Back-pressure: fill to DEPTH, stall, release, resume
        do_reset(1);
        ticks(8);
        #1;
        chk("bp_nreq", 64'(nreq), 4);
        chk("bp_req_off", imem_req, 0);
        chk("bp_valid", instr_valid, 1);
        chk("bp_head", instr_pc, 64'h100);
        expect_run(64'h100, 6);
        drain(30);
        chk("bp_resumed", 64'(nreq > 4), 1);

        // Conditional branch, -1 offset, two stale responses in flight
        do_reset(3);
        decode_ready = 1'b1;
        ticks(2);
        branch(1'b0, 26'h2A7FFFF, 64'h200);
        #1;
        chk("br19_req", imem_req, 0);
        chk("br19_valid", instr_valid, 0);
        tick();
        br_taken = 1'b0;
        #1;
        chk("br19_addr", imem_addr, 64'h1FC);
        chk("br19_req_held", imem_req, 0);
        expect_run(64'h1FC, 3);
        drain(40);

        // Unconditional branch with a response arriving in the redirect cycle
        do_reset(1);
        ticks(2);
        branch(1'b1, 26'h0000010, 64'h1000);
        #1;
        chk("br26_rsp_present", imem_rvalid, 1);
        chk("br26_valid_mask", instr_valid, 0);
        tick();
        br_taken = 1'b0;
        #1;
        chk("br26_addr", imem_addr, 64'h1040);
        chk("br26_flushed", instr_valid, 0);
        expect_run(64'h1040, 3);
        drain(30);

        // fetch_pc wrap past 2^64 and queue pointer wrap
        do_reset(1);
        branch(1'b1, 26'h3FFFFFE, 64'h0);
        tick();
        br_taken = 1'b0;
        #1;
        chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        ticks(8);
        #1;
        chk("wrap_full_req", imem_req, 0);
        chk("wrap_full_valid", instr_valid, 1);
        expect_run(64'hFFFF_FFFF_FFFF_FFF8, 10);
        drain(40);

        // Spurious response is sticky and harmless; reset clears it
        do_reset(1);
        inj_rv = 1'b1;
        tick();
        inj_rv = 1'b0;
        chk("spur_set", err_spurious, 1);
        expect_run(64'h100, 3);
        drain(30);
        chk("spur_held", err_spurious, 1);
        do_reset(1);
        ticks(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
